// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, the instruction ROM, decode and trap/redirect sources.
// master = fetch_sequencer side, slave = ROM/decode/core side.
interface fetch_sequencer_if;
    logic [31:0] imem_pc;
    logic [31:0] imem_id;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_fault;
    logic        id_ready;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        illop_req;
    logic        irq;
    logic [31:0] xp_out;
    logic        xp_we;
    logic        sup;

    modport master (
        output imem_pc, input imem_id,
        output id_valid, output id_instr, output id_pc, output id_fault, input id_ready,
        input redirect_vld, input redirect_pc, input illop_req, input irq,
        output xp_out, output xp_we, output sup
    );

    modport slave (
        input imem_pc, output imem_id,
        input id_valid, input id_instr, input id_pc, input id_fault, output id_ready,
        output redirect_vld, output redirect_pc, output illop_req, output irq,
        input xp_out, input xp_we, input sup
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC owner / ROM sequencer with a 2-entry queue to decode; handles redirects, illop traps, irq.
// Latency: first id 2 cycles after reset, 1 cycle after a flush; backpressure: id_ready=0 fills the queue and freezes fetch.
module fetch_sequencer #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_01F0,
    parameter logic [31:0] XADR_ADDR  = 32'h8000_01F8,
    parameter int unsigned IMEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    state_t      state, state_nxt;
    entry_t      q [2];
    entry_t      head_ent;
    logic [31:0] fetch_pc;
    logic        head;
    logic        tail;
    logic [1:0]  count;
    logic        sup_r;
    logic        stop;
    logic [31:0] xp_out_r;
    logic        xp_we_r;

    logic        valid;
    logic        fault_now;
    logic        take_illop, take_irq, take_redir, flush;
    logic        push, pop;

    assign valid     = (count != 2'd0);
    assign head_ent  = q[head];
    assign tail      = head ^ count[0];
    assign fault_now = ({3'b000, fetch_pc[30:2]} >= IMEM_WORDS);

    assign bus.imem_pc  = {1'b0, fetch_pc[30:2], 2'b00};
    assign bus.id_valid = valid;
    assign bus.id_instr = valid ? head_ent.instr : 32'h0;
    assign bus.id_pc    = valid ? head_ent.pc    : 32'h0;
    assign bus.id_fault = valid & head_ent.fault;
    assign bus.xp_out   = xp_out_r;
    assign bus.xp_we    = xp_we_r;
    assign bus.sup      = sup_r;

    always_ff @(posedge clk) begin
        if (rst) state <= S_BOOT;
        else     state <= state_nxt;
    end

    // Event priority illop > irq > redirect; any taken event squashes both pop and push.
    always_comb begin
        state_nxt  = state;
        take_illop = 1'b0;
        take_irq   = 1'b0;
        take_redir = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (valid && bus.illop_req)          take_illop = 1'b1;
        else if (valid && bus.irq && !sup_r) take_irq   = 1'b1;
        else if (bus.redirect_vld)           take_redir = 1'b1;
        flush = take_illop | take_irq | take_redir;
        pop   = valid & bus.id_ready & ~flush;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            default: begin
                state_nxt = S_RUN;
                push      = ~stop & ((count != 2'd2) | pop);
            end
        endcase
        if (flush) begin
            state_nxt = S_FLUSH;
            push      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[tail] <= '{fetch_pc, (fault_now ? 32'h0 : bus.imem_id), fault_now};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_ADDR;
            head     <= 1'b0;
            count    <= 2'd0;
            sup_r    <= 1'b1;
            stop     <= 1'b0;
            xp_out_r <= 32'h0;
            xp_we_r  <= 1'b0;
        end else begin
            xp_we_r <= take_illop | take_irq;
            if (flush) begin
                head  <= 1'b0;
                count <= 2'd0;
                stop  <= 1'b0;
                if (take_illop || take_irq) begin
                    fetch_pc <= take_illop ? ILLOP_ADDR : XADR_ADDR;
                    sup_r    <= 1'b1;
                    xp_out_r <= head_ent.pc + 32'd4;
                end else begin
                    // User mode cannot raise the supervisor bit through a jump.
                    fetch_pc <= {bus.redirect_pc[31] & sup_r, bus.redirect_pc[30:0] & 31'h7FFF_FFFC};
                    sup_r    <= bus.redirect_pc[31] & sup_r;
                end
            end else begin
                if (push) begin
                    fetch_pc <= {fetch_pc[31], fetch_pc[30:0] + 31'd4};
                    if (fault_now) stop <= 1'b1;
                end
                if (pop) head <= ~head;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: ROM model plus an expected-PC scoreboard.
module tb_fetch_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] exp_q [$];

    fetch_sequencer_if bus ();

    fetch_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h5A00_0000 ^ (a * 32'h0001_0003);
    endfunction

    function automatic logic exp_fault(input logic [31:0] pc);
        return ({3'b000, pc[30:2]} >= 32'd128);
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return exp_fault(pc) ? 32'h0 : rom({1'b0, pc[30:2], 2'b00});
    endfunction

    assign bus.imem_id = rom(bus.imem_pc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back({start[31], start[30:0] + 31'(4 * i)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.id_ready = 1'b1; bus.redirect_vld = 1'b0; bus.redirect_pc = 32'h0;
        bus.illop_req = 1'b0; bus.irq = 1'b0;
        tick(); tick();
        checks++; if (bus.id_valid !== 1'b0) $display("FAIL reset_id_valid: got %0b want 0", bus.id_valid); else passes++;
        checks++; if (bus.id_pc !== 32'h0) $display("FAIL reset_id_pc: got %h want 0", bus.id_pc); else passes++;
        checks++; if (bus.id_instr !== 32'h0) $display("FAIL reset_id_instr: got %h want 0", bus.id_instr); else passes++;
        checks++; if (bus.sup !== 1'b1) $display("FAIL reset_sup: got %0b want 1", bus.sup); else passes++;
        checks++; if (bus.xp_we !== 1'b0 || bus.xp_out !== 32'h0)
            $display("FAIL reset_xp: got we=%0b out=%h want we=0 out=0", bus.xp_we, bus.xp_out); else passes++;
    endtask

    task automatic test_boot_stream();
        logic [31:0] e;
        load_exp(32'h8000_0000, 16);
        rst = 1'b0;
        tick();
        checks++; if (bus.id_valid !== 1'b0) $display("FAIL boot_early_valid: got %0b want 0", bus.id_valid); else passes++;
        tick();
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e) || bus.id_fault !== exp_fault(e))
                $display("FAIL boot_stream: got v=%0b pc=%h i=%h f=%0b want pc=%h i=%h f=%0b",
                         bus.id_valid, bus.id_pc, bus.id_instr, bus.id_fault, e, exp_instr(e), exp_fault(e));
            else passes++;
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        bus.id_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.id_pc !== exp_q[0]) $display("FAIL stall_id_pc: got %h want %h", bus.id_pc, exp_q[0]); else passes++;
        end
        checks++; if (bus.imem_pc !== 32'h0000_0014) $display("FAIL stall_imem_pc: got %h want 00000014", bus.imem_pc); else passes++;
        bus.id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e))
                $display("FAIL stall_resume: got v=%0b pc=%h i=%h want pc=%h i=%h",
                         bus.id_valid, bus.id_pc, bus.id_instr, e, exp_instr(e));
            else passes++;
            tick();
        end
    endtask

    task automatic test_redirect();
        logic [31:0] e;
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h0000_0050;
        tick();
        bus.redirect_vld = 1'b0;
        checks++; if (bus.id_valid !== 1'b0 || bus.sup !== 1'b0)
            $display("FAIL redir_flush: got v=%0b sup=%0b want v=0 sup=0", bus.id_valid, bus.sup); else passes++;
        load_exp(32'h0000_0050, 8);
        tick();
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e))
                $display("FAIL redir_stream: got v=%0b pc=%h i=%h want pc=%h i=%h",
                         bus.id_valid, bus.id_pc, bus.id_instr, e, exp_instr(e));
            else passes++;
            tick();
        end
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h8000_0000;
        tick();
        bus.redirect_vld = 1'b0;
        load_exp(32'h0000_0000, 8);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.sup !== 1'b0)
            $display("FAIL redir_user_strip: got v=%0b pc=%h sup=%0b want pc=%h sup=0", bus.id_valid, bus.id_pc, bus.sup, e);
        else passes++;
    endtask

    task automatic test_irq_priority();
        logic [31:0] e;
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h0000_0058;
        tick();
        bus.redirect_vld = 1'b0;
        tick();
        checks++; if (bus.id_pc !== 32'h58 || bus.sup !== 1'b0)
            $display("FAIL irq_setup: got pc=%h sup=%0b want pc=00000058 sup=0", bus.id_pc, bus.sup); else passes++;
        bus.irq = 1'b1; bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h0000_0100;
        tick();
        bus.redirect_vld = 1'b0;
        checks++; if (bus.xp_we !== 1'b1 || bus.xp_out !== 32'h5C || bus.sup !== 1'b1 || bus.id_valid !== 1'b0)
            $display("FAIL irq_taken: got we=%0b xp=%h sup=%0b v=%0b want we=1 xp=0000005c sup=1 v=0",
                     bus.xp_we, bus.xp_out, bus.sup, bus.id_valid); else passes++;
        load_exp(32'h8000_01F8, 3);
        tick();
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e) || bus.xp_we !== 1'b0)
                $display("FAIL irq_vector: got v=%0b pc=%h i=%h we=%0b want pc=%h i=%h we=0",
                         bus.id_valid, bus.id_pc, bus.id_instr, bus.xp_we, e, exp_instr(e));
            else passes++;
            tick();
        end
        checks++; if (bus.xp_we !== 1'b0 || bus.sup !== 1'b1)
            $display("FAIL irq_ignored_sup: got we=%0b sup=%0b want we=0 sup=1", bus.xp_we, bus.sup); else passes++;
        bus.irq = 1'b0;
    endtask

    task automatic test_fault_illop();
        logic [31:0] e;
        bus.redirect_vld = 1'b1; bus.redirect_pc = 32'h0000_01FC;
        tick();
        bus.redirect_vld = 1'b0;
        load_exp(32'h0000_01FC, 2);
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e) || bus.id_fault !== 1'b0)
            $display("FAIL last_word: got v=%0b pc=%h i=%h f=%0b want pc=%h i=%h f=0",
                     bus.id_valid, bus.id_pc, bus.id_instr, bus.id_fault, e, exp_instr(e));
        else passes++;
        tick();
        bus.id_ready = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e) || bus.id_fault !== exp_fault(e))
            $display("FAIL fault_entry: got v=%0b pc=%h i=%h f=%0b want pc=%h i=%h f=%0b",
                     bus.id_valid, bus.id_pc, bus.id_instr, bus.id_fault, e, exp_instr(e), exp_fault(e));
        else passes++;
        tick(); tick(); tick();
        checks++; if (bus.imem_pc !== 32'h0000_0204 || bus.id_pc !== 32'h200)
            $display("FAIL fault_stops_fetch: got imem=%h pc=%h want imem=00000204 pc=00000200", bus.imem_pc, bus.id_pc); else passes++;
        bus.illop_req = 1'b1;
        tick();
        bus.illop_req = 1'b0;
        checks++; if (bus.xp_we !== 1'b1 || bus.xp_out !== 32'h204 || bus.sup !== 1'b1 || bus.id_valid !== 1'b0)
            $display("FAIL illop_taken: got we=%0b xp=%h sup=%0b v=%0b want we=1 xp=00000204 sup=1 v=0",
                     bus.xp_we, bus.xp_out, bus.sup, bus.id_valid); else passes++;
        load_exp(32'h8000_01F0, 4);
        bus.id_ready = 1'b1;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e) || bus.xp_we !== 1'b0)
            $display("FAIL illop_vector: got v=%0b pc=%h i=%h we=%0b want pc=%h i=%h we=0",
                     bus.id_valid, bus.id_pc, bus.id_instr, bus.xp_we, e, exp_instr(e));
        else passes++;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        bus.id_ready = 1'b0;
        tick(); tick();
        rst = 1'b1; bus.irq = 1'b1;
        tick();
        checks++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'h0 || bus.id_instr !== 32'h0 || bus.id_fault !== 1'b0 ||
            bus.xp_we !== 1'b0 || bus.xp_out !== 32'h0 || bus.sup !== 1'b1 || bus.imem_pc !== 32'h0)
            $display("FAIL mid_reset: got v=%0b pc=%h i=%h f=%0b we=%0b xp=%h sup=%0b imem=%h want all zero, sup=1",
                     bus.id_valid, bus.id_pc, bus.id_instr, bus.id_fault, bus.xp_we, bus.xp_out, bus.sup, bus.imem_pc);
        else passes++;
        rst = 1'b0; bus.irq = 1'b0; bus.id_ready = 1'b1;
        load_exp(32'h8000_0000, 8);
        tick();
        checks++; if (bus.id_valid !== 1'b0) $display("FAIL restart_early_valid: got %0b want 0", bus.id_valid); else passes++;
        tick();
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== e || bus.id_instr !== exp_instr(e))
                $display("FAIL restart_stream: got v=%0b pc=%h i=%h want pc=%h i=%h",
                         bus.id_valid, bus.id_pc, bus.id_instr, e, exp_instr(e));
            else passes++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot_stream();
        test_stall();
        test_redirect();
        test_irq_priority();
        test_fault_illop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
